mx_block_quant_ctrl: RTL and testbench

MX_BLOCK_QUANT_CTRL -- requirements
Module: mx_block_quant_ctrl

---
 rtl/mx_block_quant_ctrl_if.sv | 26 ++
 rtl/mx_block_quant_ctrl.sv | 140 ++++++++++++++
 tb/tb_mx_block_quant_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mx_block_quant_ctrl_if.sv
// Streaming bus for the MX block quantiser: the FP32 element input handshake and
// the quantised element output handshake with its shared scale.
interface mx_block_quant_ctrl_if #(
    parameter int MAN_W = 4
);
    logic [31:0]      i_data;
    logic             i_valid;
    logic             o_ready;
    logic             o_valid;
    logic             i_ready;
    logic             o_sign;
    logic [MAN_W-1:0] o_man;
    logic [7:0]       o_scale;
    logic             o_ofl;
    logic             o_last;

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_valid, o_sign, o_man, o_scale, o_ofl, o_last
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_valid, o_sign, o_man, o_scale, o_ofl, o_last
    );
endinterface

// File: rtl/mx_block_quant_ctrl.sv
// MX block quantiser: buffers BLOCK_SIZE FP32 elements, finds the shared exponent,
// then drains RNE-rounded aligned mantissas. Optional macro MX_RND_SAT_EN saturates on overflow.
module mx_block_quant_ctrl #(
    parameter int BLOCK_SIZE = 32,
    parameter int MAN_W      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    mx_block_quant_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [23:0] STICKY_MASK = (24'd1 << (23 - MAN_W)) - 24'd1;

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_buf [BLOCK_SIZE];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [7:0]       r_max_exp;
    logic [7:0]       r_scale;

    logic             w_ready;
    logic             w_valid;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [7:0]       w_in_exp;
    logic [7:0]       w_max_next;

    logic [31:0]       w_elem_p0;
    logic [7:0]        w_exp_p0;
    logic signed [9:0] w_shift_p0;
    logic [23:0]       w_aug_p0;
    logic [23:0]       w_shifted_p0;
    logic [MAN_W:0]    w_rounded_p0;

    // Returns {carry, sum}: the top MAN_W bits plus the round-to-nearest-even increment.
    function automatic logic [MAN_W:0] rne_round(input logic [23:0] v);
        logic [MAN_W-1:0] kept;
        logic             rnd;
        logic             sticky;
        logic             up;
        kept   = v[23 -: MAN_W];
        rnd    = v[23 - MAN_W];
        sticky = |(v & STICKY_MASK);
        up     = rnd & (kept[0] | sticky);
        return {1'b0, kept} + (MAN_W + 1)'(up);
    endfunction

    function automatic logic [MAN_W-1:0] ofl_man(input logic [MAN_W:0] s);
`ifdef MX_RND_SAT_EN
        return s[MAN_W] ? {MAN_W{1'b1}} : s[MAN_W-1:0];
`else
        return s[MAN_W-1:0];
`endif
    endfunction

    assign w_in_xfer  = bus.i_valid && w_ready;
    assign w_out_xfer = w_valid && bus.i_ready;
    assign w_wr_last  = (r_wr_idx == LAST_IDX);
    assign w_rd_last  = (r_rd_idx == LAST_IDX);
    assign w_in_exp   = bus.i_data[30:23];
    // The first element of a block restarts the running maximum.
    assign w_max_next = (r_wr_idx == '0 || w_in_exp > r_max_exp) ? w_in_exp : r_max_exp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_FILL: begin
                w_ready = 1'b1;
                if (w_in_xfer && w_wr_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_valid = 1'b1;
                if (w_out_xfer && w_rd_last) begin
                    w_next = S_FILL;
                end
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_max_exp <= '0;
            r_scale   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_wr_idx  <= w_wr_last ? '0 : r_wr_idx + 1'b1;
                r_max_exp <= w_max_next;
                if (w_wr_last) begin
                    r_scale <= w_max_next;
                end
            end
            if (w_out_xfer) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_in_xfer) begin
            r_buf[r_wr_idx] <= bus.i_data;
        end
    end

    // Stage p0: align the buffered element to the shared scale and round.
    assign w_elem_p0    = r_buf[r_rd_idx];
    assign w_exp_p0     = w_elem_p0[30:23];
    assign w_aug_p0     = {(w_exp_p0 != 8'd0), w_elem_p0[22:0]};
    assign w_shift_p0   = $signed({2'b00, r_scale}) - $signed({2'b00, w_exp_p0});
    assign w_shifted_p0 = (w_shift_p0 >= 10'sd24) ? 24'd0 : (w_aug_p0 >> w_shift_p0[4:0]);
    assign w_rounded_p0 = rne_round(w_shifted_p0);

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_scale = r_scale;
    assign bus.o_sign  = w_valid & w_elem_p0[31];
    assign bus.o_man   = w_valid ? ofl_man(w_rounded_p0) : '0;
    assign bus.o_ofl   = w_valid & w_rounded_p0[MAN_W];
    assign bus.o_last  = w_valid & w_rd_last;
endmodule

// File: tb/tb_mx_block_quant_ctrl.sv
// Randomised and directed bench for mx_block_quant_ctrl against a block-level model.
module tb_mx_block_quant_ctrl;
    localparam int BS = 4;
    localparam int MW = 4;
`ifdef MX_RND_SAT_EN
    localparam logic [MW-1:0] OFL_MAN = '1;
`else
    localparam logic [MW-1:0] OFL_MAN = '0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mx_block_quant_ctrl_if #(.MAN_W(MW)) bus ();

    mx_block_quant_ctrl #(.BLOCK_SIZE(BS), .MAN_W(MW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic          sign;
        logic [MW-1:0] man;
        logic          ofl;
        logic          last;
    } exp_t;

    typedef struct {
        int man;
        int ofl;
        int scale;
    } dir_t;

    int          total = 0;
    int          bad   = 0;
    bit          m_fill = 1'b1;
    logic [31:0] m_in[$];
    exp_t        m_out[$];
    int          m_scale = 0;
    dir_t        dir_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Exact integer view: 24-bit aligned value split into kept quotient and remainder.
    function automatic logic [MW:0] ref_q(input logic [31:0] d, input int scale);
        int     e;
        int     sh;
        longint x;
        longint unit;
        longint q;
        longint rem;
        e = int'(d[30:23]);
        sh = scale - e;
        x = longint'(d[22:0]);
        if (e != 0) x = x + 64'sd8388608;
        if (sh >= 24) x = 0;
        else x = x / (64'sd1 <<< sh);
        unit = 64'sd1 <<< (24 - MW);
        q = x / unit;
        rem = x % unit;
        if (rem > unit / 2 || (rem == unit / 2 && (q % 2) == 1)) q = q + 1;
        if (q == (64'sd1 <<< MW)) return {1'b1, OFL_MAN};
        return {1'b0, MW'(q)};
    endfunction

    task automatic build_block();
        logic [MW:0] r;
        exp_t        e;
        m_scale = 0;
        foreach (m_in[i]) if (int'(m_in[i][30:23]) > m_scale) m_scale = int'(m_in[i][30:23]);
        foreach (m_in[i]) begin
            r = ref_q(m_in[i], m_scale);
            e.sign = m_in[i][31];
            e.man  = r[MW-1:0];
            e.ofl  = r[MW];
            e.last = (i == BS - 1);
            m_out.push_back(e);
        end
        m_in.delete();
        m_fill = 1'b0;
    endtask

    // One cycle: inputs are already driven; check outputs, predict the edge, advance.
    task automatic step();
        exp_t e;
        dir_t d;
        if (rst) begin
            m_fill = 1'b1;
            m_in.delete();
            m_out.delete();
        end else begin
            check("o_ready", 32'(bus.o_ready), 32'(m_fill));
            check("o_valid", 32'(bus.o_valid), 32'(!m_fill));
            if (!m_fill) begin
                e = m_out[0];
                check("o_sign", 32'(bus.o_sign), 32'(e.sign));
                check("o_man", 32'(bus.o_man), 32'(e.man));
                check("o_ofl", 32'(bus.o_ofl), 32'(e.ofl));
                check("o_last", 32'(bus.o_last), 32'(e.last));
                check("o_scale", 32'(bus.o_scale), 32'(m_scale));
                if (bus.i_ready) begin
                    void'(m_out.pop_front());
                    if (dir_q.size() > 0) begin
                        d = dir_q.pop_front();
                        check("dir_man", 32'(bus.o_man), 32'(d.man));
                        check("dir_ofl", 32'(bus.o_ofl), 32'(d.ofl));
                        check("dir_scale", 32'(bus.o_scale), 32'(d.scale));
                    end
                    if (m_out.size() == 0) m_fill = 1'b1;
                end
            end else if (bus.i_valid) begin
                m_in.push_back(bus.i_data);
                if (m_in.size() == BS) build_block();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_scale", 32'(bus.o_scale), 32'd0);
        check("rst_man", 32'(bus.o_man), 32'd0);
        check("rst_sign", 32'(bus.o_sign), 32'd0);
        check("rst_ofl", 32'(bus.o_ofl), 32'd0);
        check("rst_last", 32'(bus.o_last), 32'd0);
    endtask

    task automatic feed(input logic [31:0] v);
        bit acc;
        bit done;
        done = 1'b0;
        bus.i_data = v;
        bus.i_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            acc = m_fill && !rst;
            step();
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        bus.i_valid = 1'b0;
        check("feed_done", 32'(done), 32'd1);
    endtask

    task automatic drain();
        bus.i_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (m_fill) break;
            step();
        end
        check("drain_done", 32'(m_fill), 32'd1);
        check("dir_left", 32'(dir_q.size()), 32'd0);
    endtask

    task automatic expect_dir(input int man, input int ofl, input int scale);
        dir_t d;
        d.man = man;
        d.ofl = ofl;
        d.scale = scale;
        dir_q.push_back(d);
    endtask

    initial begin
        bus.i_data  = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        do_reset();

        expect_dir(4, 0, 128); expect_dir(8, 0, 128); expect_dir(6, 0, 128); expect_dir(0, 0, 128);
        feed(32'h3F800000); feed(32'h40000000); feed(32'h3FC00000); feed(32'h00000000);
        drain();

        expect_dir(8, 0, 127); expect_dir(10, 0, 127); expect_dir(8, 0, 127); expect_dir(8, 0, 127);
        feed(32'h3F880000); feed(32'h3F980000); feed(32'h3F800000); feed(32'h3F800000);
        drain();

        expect_dir(8, 0, 127); expect_dir(int'(OFL_MAN), 1, 127); expect_dir(8, 0, 127); expect_dir(8, 0, 127);
        feed(32'h3F800000); feed(32'h3FFC0000); feed(32'h3F800000); feed(32'h3F800000);
        drain();

        // Stall mid-drain: the per-cycle model check covers stability while stalled.
        feed(32'h3F800000); feed(32'hC0000000); feed(32'h3FC00000); feed(32'h3F900000);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        for (int n = 0; n < 5; n++) step();
        drain();

        feed(32'h7F000000); feed(32'h7F000000);
        do_reset();
        expect_dir(8, 0, 129); expect_dir(2, 0, 129); expect_dir(4, 0, 129); expect_dir(6, 0, 129);
        feed(32'h40800000); feed(32'h3F800000); feed(32'h40000000); feed(32'h40400000);
        drain();

        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        for (int n = 0; n < 4 * BS + 3; n++) begin
            bus.i_data = $urandom;
            step();
        end
        bus.i_valid = 1'b0;
        drain();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       bus.i_data = {1'($urandom), 8'd0, 23'($urandom)};
                1:       bus.i_data = {1'($urandom), 8'd255, 23'($urandom)};
                2:       bus.i_data = $urandom;
                default: bus.i_data = {1'($urandom), 8'($urandom_range(118, 130)), 23'($urandom)};
            endcase
            step();
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
